// File: rtl/controller.sv
// Purpose: sequencing controller for an 8-phase accumulator CPU with a halt state.
// Latency: one phase per clock; all outputs decode the current state, opcode and zero.
// Backpressure: none; the phase sequence free-runs until HLT or reset.
module controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  input  logic       zero,
  output logic       sel,
  output logic       rd,
  output logic       ld_ir,
  output logic       inc_pc,
  output logic       ld_pc,
  output logic       ld_ac,
  output logic       wr,
  output logic       data_e,
  output logic       halt,
  output logic [2:0] phase
);

  localparam logic [2:0] OP_HLT = 3'b000;
  localparam logic [2:0] OP_SKZ = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_LDA = 3'b101;
  localparam logic [2:0] OP_STO = 3'b110;
  localparam logic [2:0] OP_JMP = 3'b111;

  // Bit 3 is the halt flag; the low three bits are the visible phase, so
  // HALTED reads back as phase 0 while staying distinct from INST_ADDR.
  typedef enum logic [3:0] {
    S_INST_ADDR  = 4'd0,
    S_INST_FETCH = 4'd1,
    S_INST_LOAD  = 4'd2,
    S_IDLE       = 4'd3,
    S_OP_ADDR    = 4'd4,
    S_OP_FETCH   = 4'd5,
    S_ALU_OP     = 4'd6,
    S_STORE      = 4'd7,
    S_HALTED     = 4'd8
  } state_e;

  state_e state_q;
  state_e state_d;
  logic   aluop;

  assign aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                 (opcode == OP_XOR) || (opcode == OP_LDA);

  assign phase = state_q[2:0];

  // Next phase: wrap through all eight phases; HLT seen at OP_ADDR parks in HALTED.
  always_comb begin
    state_d = state_q;
    if (state_q == S_HALTED) begin
      state_d = S_HALTED;
    end else if ((state_q == S_OP_ADDR) && (opcode == OP_HLT)) begin
      state_d = S_HALTED;
    end else begin
      state_d = state_e'({1'b0, state_q[2:0] + 3'd1});
    end
  end

  // State register; reset drops straight back to INST_ADDR from any state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INST_ADDR;
    end else begin
      state_q <= state_d;
    end
  end

  // Output decode; opcode only matters from OP_ADDR onward, zero only for SKZ in ALU_OP.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    unique case (state_q)
      S_INST_ADDR: begin
        sel = 1'b1;
      end
      S_INST_FETCH: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      S_INST_LOAD, S_IDLE: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      S_OP_ADDR: begin
        inc_pc = 1'b1;
        halt   = (opcode == OP_HLT);
      end
      S_OP_FETCH: begin
        rd = aluop;
      end
      S_ALU_OP: begin
        rd     = aluop;
        inc_pc = (opcode == OP_SKZ) && zero;
        ld_pc  = (opcode == OP_JMP);
        data_e = (opcode == OP_STO);
      end
      S_STORE: begin
        rd     = aluop;
        ld_ac  = aluop;
        ld_pc  = (opcode == OP_JMP);
        wr     = (opcode == OP_STO);
        data_e = (opcode == OP_STO);
      end
      S_HALTED: begin
        halt = 1'b1;
      end
      default: begin
        sel = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_controller.sv
// Purpose: self-checking bench for controller against a phase-level reference model.
// Latency: outputs compared mid-cycle at every negedge and 1 ns into each reset pulse.
// Backpressure: none; stimulus is directed instruction runs followed by random opcodes and resets.
module tb_controller;

  logic       clk;
  logic       rst;
  logic [2:0] opcode;
  logic       zero;
  logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;

  // reference model state: which of the eight phases we are in, and whether halted
  int m_phase  = 0;
  bit m_halted = 0;

  controller dut (
    .clk    (clk),
    .rst    (rst),
    .opcode (opcode),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .ld_pc  (ld_pc),
    .ld_ac  (ld_ac),
    .wr     (wr),
    .data_e (data_e),
    .halt   (halt),
    .phase  (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h (phase %0d halted %0d opcode %0d zero %0d)",
               tag, obs, exp_v, m_phase, m_halted, opcode, zero);
    end
  endtask

  function automatic logic [31:0] obs_vec();
    return {20'd0, phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt};
  endfunction

  // Expected outputs from what each phase does to the CPU, not from the RTL's decode.
  function automatic logic [31:0] exp_vec();
    bit fetching, reads_mem, is_jmp, is_sto, is_skz;
    logic e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt;
    int p;
    p         = m_halted ? 0 : m_phase;
    fetching  = !m_halted && (m_phase < 4);
    reads_mem = (opcode >= 3'd2) && (opcode <= 3'd5);
    is_jmp    = (opcode == 3'd7);
    is_sto    = (opcode == 3'd6);
    is_skz    = (opcode == 3'd1);
    e_sel  = fetching;
    e_rd   = fetching ? (m_phase != 0) : (!m_halted && m_phase >= 5 && reads_mem);
    e_ldir = fetching && (m_phase >= 2);
    e_inc  = !m_halted && ((m_phase == 4) || (m_phase == 6 && is_skz && zero));
    e_ldpc = !m_halted && (m_phase >= 6) && is_jmp;
    e_ldac = !m_halted && (m_phase == 7) && reads_mem;
    e_wr   = !m_halted && (m_phase == 7) && is_sto;
    e_de   = !m_halted && (m_phase >= 6) && is_sto;
    e_halt = m_halted || (m_phase == 4 && opcode == 3'd0);
    return {20'd0, 3'(p), e_sel, e_rd, e_ldir, e_inc, e_ldpc, e_ldac, e_wr, e_de, e_halt};
  endfunction

  function automatic void model_step();
    if (!rst) begin
      m_phase  = 0;
      m_halted = 0;
    end else if (!m_halted) begin
      if (m_phase == 4 && opcode == 3'd0) m_halted = 1;
      else m_phase = (m_phase + 1) % 8;
    end
  endfunction

  // One clock: drive inputs just after posedge, optionally pulse reset for 3 ns,
  // compare at negedge, then advance the model on the next posedge.
  task automatic cycle(input logic [2:0] op, input logic z, input bit pulse, input string tag);
    opcode = op;
    zero   = z;
    if (pulse) begin
      rst = 1'b0;
      #1;
      m_phase  = 0;
      m_halted = 0;
      chk({tag, "_arst"}, obs_vec(), exp_vec());
      #2;
      rst = 1'b1;
    end
    @(negedge clk);
    chk(tag, obs_vec(), exp_vec());
    chk({tag, "_wr_excl"}, {31'd0, (wr & ld_ac) | (wr & rd)}, 32'd0);
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst    = 1'b0;
    opcode = 3'd0;
    zero   = 1'b0;
    #1;
    // held in reset for two cycles, then released away from the edge
    for (int i = 0; i < 2; i++) cycle(3'($urandom_range(7)), 1'($urandom_range(1)), 0, "reset_hold");
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cycle(3'd5, 1'b0, 0, "lda");
    for (int i = 0; i < 8; i++) cycle(3'd6, 1'b1, 0, "sto");
    for (int i = 0; i < 8; i++) cycle(3'd1, 1'b1, 0, "skz_z1");
    for (int i = 0; i < 8; i++) cycle(3'd1, 1'b0, 0, "skz_z0");
    for (int i = 0; i < 8; i++) cycle(3'd7, 1'b0, 0, "jmp");
    for (int i = 0; i < 8; i++) cycle(3'(2 + (i % 3)), 1'($urandom_range(1)), 0, "alu");

    // reset pulse while JMP is sitting in ALU_OP
    for (int i = 0; i < 6; i++) cycle(3'd7, 1'b0, 0, "jmp_pre");
    cycle(3'd7, 1'b0, 1, "jmp_rst");
    for (int i = 0; i < 7; i++) cycle(3'd7, 1'b0, 0, "jmp_post");

    // HLT, then stay halted regardless of opcode/zero, then escape by reset
    for (int i = 0; i < 5; i++) cycle(3'd0, 1'b0, 0, "hlt");
    for (int i = 0; i < 6; i++) cycle(3'($urandom_range(7)), 1'($urandom_range(1)), 0, "halted");
    cycle(3'd5, 1'b0, 1, "halt_rst");
    for (int i = 0; i < 7; i++) cycle(3'd3, 1'b0, 0, "after_halt");

    // random opcodes/zero changing every phase, with occasional async resets
    for (int i = 0; i < 800; i++) begin
      bit pulse;
      pulse = (m_halted && ($urandom_range(3) == 0)) || ($urandom_range(39) == 0);
      cycle(3'($urandom_range(7)), 1'($urandom_range(1)), pulse, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
